// File: rtl/ring_pkg.sv
// ring_pkg: shared state encoding, rotation helper and default lock thresholds.
package ring_pkg;
  typedef enum logic [1:0] {IDLE, HUNT, LOCKED} state_t;
  localparam int LOCK_N_DEF = 3;
  localparam int UNLOCK_N_DEF = 2;
  function automatic logic [3:0] rot(input logic [3:0] v, input logic dir);
    return dir ? {v[0], v[3:1]} : {v[2:0], v[3]};
  endfunction
endpackage

// File: rtl/sat_cnt8.sv
// sat_cnt8: 8-bit up counter that sticks at 255.
module sat_cnt8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  output logic [7:0] cnt
);
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (inc && cnt != 8'hFF) cnt <= cnt + 8'd1;
endmodule

// File: rtl/ring_monitor.sv
// ring_monitor: locks onto a rotating one-hot-style ring pattern and counts rotations/errors.
module ring_monitor
  import ring_pkg::*;
#(
  parameter bit DIR      = 1'b0,
  parameter int LOCK_N   = LOCK_N_DEF,
  parameter int UNLOCK_N = UNLOCK_N_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] ring_in,
  input  logic       ring_valid,
  output logic       locked,
  output logic       err,
  output logic [1:0] pos,
  output logic [7:0] rot_cnt,
  output logic [7:0] mis_cnt
);
  state_t     state;
  logic [3:0] prev;
  logic [7:0] good_cnt, bad_cnt;
  logic       stuck, good, mis_inc;
  always_comb begin
    stuck   = ring_in == 4'h0 || ring_in == 4'hF;
    good    = !stuck && ring_in == rot(prev, DIR);
    mis_inc = ring_valid && state == LOCKED && !good;
  end
  sat_cnt8 u_mis (.clk(clk), .reset(reset), .inc(mis_inc), .cnt(mis_cnt));
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      prev     <= '0;
      good_cnt <= '0;
      bad_cnt  <= '0;
      locked   <= 1'b0;
      err      <= 1'b0;
      pos      <= '0;
      rot_cnt  <= '0;
    end else begin
      err <= mis_inc;
      if (ring_valid) begin
        prev <= ring_in;
        case (state)
          IDLE: begin
            good_cnt <= '0;
            state    <= HUNT;
          end
          HUNT:
            if (!good) good_cnt <= '0;
            else if (32'(good_cnt) + 1 >= LOCK_N) begin
              state   <= LOCKED;
              locked  <= 1'b1;
              pos     <= '0;
              bad_cnt <= '0;
            end else good_cnt <= good_cnt + 8'd1;
          LOCKED:
            if (good) begin
              rot_cnt <= rot_cnt + 8'd1;
              pos     <= pos + 2'd1;
              bad_cnt <= '0;
            end else if (stuck || 32'(bad_cnt) + 1 >= UNLOCK_N) begin
              state    <= HUNT;
              locked   <= 1'b0;
              good_cnt <= '0;
            end else bad_cnt <= bad_cnt + 8'd1;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
